// File: rtl/cache_arb_pkg.sv
// Shared types and sizes for the cache line arbiter: FSM states, owner
// encoding, line/beat geometry and the line-alignment helper.
package cache_arb_pkg;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W = 2;
  localparam int ADDR_W     = 32;
  localparam int OFFSET_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } owner_t;

  // Clear the byte offset within a 32-byte line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/arb_line_buffer.sv
// One cache line of storage. A full-line load captures a writeback line at
// grant; the beat write port fills the line one memory beat at a time on
// reads; the beat read mux feeds the outgoing write beat.
module arb_line_buffer
  import cache_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [LINE_W-1:0]     load_data,
  input  logic                  wr_en,
  input  logic [BEAT_IDX_W-1:0] wr_idx,
  input  logic [BEAT_W-1:0]     wr_data,
  input  logic [BEAT_IDX_W-1:0] rd_idx,
  output logic [BEAT_W-1:0]     rd_data,
  output logic [LINE_W-1:0]     line
);

  logic [LINE_W-1:0] line_q;

  // Line storage: full load takes priority over a beat write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_data;
    end else if (wr_en) begin
      line_q[wr_idx*BEAT_W +: BEAT_W] <= wr_data;
    end
  end

  assign rd_data = line_q[rd_idx*BEAT_W +: BEAT_W];
  assign line    = line_q;

endmodule

// File: rtl/cache_line_arbiter.sv
// Arbitrates icache and dcache line requests onto one physical-memory port,
// turning each 256-bit line transfer into a 4-beat 64-bit burst.
//
// Handshake: a cache holds *_pmem_read / d_pmem_write high until it sees a
// one-cycle *_pmem_resp, then drops the request the following cycle. On the
// memory side mem_read/mem_write stay high for the whole burst and each
// mem_resp pulse completes exactly one beat.
module cache_line_arbiter
  import cache_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output arb_state_t        dbg_state
);

  arb_state_t            state_q, state_d;
  logic [BEAT_IDX_W-1:0] cnt_q;
  owner_t                owner_q, last_grant_q, grant_owner;
  logic                  write_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  grant;
  logic                  d_req;
  logic                  last_beat;
  logic                  buf_load;
  logic                  buf_wr;
  logic [BEAT_W-1:0]     buf_beat;
  logic [LINE_W-1:0]     buf_line;

  assign d_req     = d_pmem_read | d_pmem_write;
  assign last_beat = mem_resp && (cnt_q == BEAT_IDX_W'(BEATS - 1));

  // Next state and round-robin arbitration; only IDLE can grant.
  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_owner = ICACHE;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_pmem_read || last_grant_q == ICACHE)) begin
          grant       = 1'b1;
          grant_owner = DCACHE;
          state_d     = BURST;
        end else if (i_pmem_read) begin
          grant       = 1'b1;
          grant_owner = ICACHE;
          state_d     = BURST;
        end
      end
      BURST:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, beat counter and the transaction latched at grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= ICACHE;
      last_grant_q <= ICACHE;
      write_q      <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_owner;
        write_q <= (grant_owner == DCACHE) && d_pmem_write;
        addr_q  <= line_align((grant_owner == DCACHE) ? d_pmem_address : i_pmem_address);
      end
      // Counter wraps back to 0 on the fourth beat, ready for the next burst.
      if (state_q == BURST && mem_resp) cnt_q <= cnt_q + BEAT_IDX_W'(1);
      if (state_q == BURST && last_beat) last_grant_q <= owner_q;
    end
  end

  assign buf_load = grant && (grant_owner == DCACHE) && d_pmem_write;
  assign buf_wr   = (state_q == BURST) && mem_resp && !write_q;

  arb_line_buffer u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_en   (buf_load),
    .load_data (d_pmem_wdata),
    .wr_en     (buf_wr),
    .wr_idx    (cnt_q),
    .wr_data   (mem_rdata),
    .rd_idx    (cnt_q),
    .rd_data   (buf_beat),
    .line      (buf_line)
  );

  // Memory strobes during BURST, completion pulse to the owner in DONE.
  always_comb begin
    mem_read    = (state_q == BURST) && !write_q;
    mem_write   = (state_q == BURST) && write_q;
    mem_address = (state_q == BURST) ? addr_q : '0;
    i_pmem_resp = (state_q == DONE) && (owner_q == ICACHE);
    d_pmem_resp = (state_q == DONE) && (owner_q == DCACHE);
  end

  assign mem_wdata    = buf_beat;
  assign i_pmem_rdata = buf_line;
  assign d_pmem_rdata = buf_line;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Bench for cache_line_arbiter: table of directed transactions, hand-written
// abort / dropped-request sequences, then randomized transactions predicted
// by a transaction-level arbitration model.
module tb_cache_line_arbiter;
  import cache_arb_pkg::*;

  typedef struct {
    logic          i_req;
    logic          d_rd;
    logic          d_wr;
    logic [31:0]   i_addr;
    logic [31:0]   d_addr;
    logic [31:0]   exp_i_addr;
    logic [31:0]   exp_d_addr;
    logic [255:0]  wdata;
    logic [255:0]  mem_line;
    int            waits;
    int            exp_first;  // 0 = icache, 1 = dcache
    int            exp_lat;    // negedges from request to first resp
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         i_pmem_read = 1'b0;
  logic [31:0]  i_pmem_address = '0;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [31:0]  d_pmem_address = '0;
  logic [255:0] d_pmem_wdata = '0;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata = '0;
  logic         mem_resp = 1'b0;
  arb_state_t   dbg_state;

  cache_line_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int           last_served = 0;   // owner most recently completed
  logic [31:0]  exp_addr = '0;
  logic         exp_mwrite = 1'b0;
  logic [255:0] exp_wline = '0;
  logic [255:0] mem_line_cur = '0;
  int           cur_wait = 0;

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  // Round robin: when both wait, the one not served last goes first.
  function automatic int pick_first(input logic i_req, input logic d_req);
    if (i_req && d_req) return (last_served == 0) ? 1 : 0;
    return d_req ? 1 : 0;
  endfunction

  // ---------------- memory responder ----------------
  int   rb_beat = 0;
  int   rb_wcnt = 0;
  logic rb_active = 1'b0;
  logic rb_drop_chk = 1'b0;

  // Beat k is accepted after cur_wait idle cycles; checks address, op,
  // write beat ordering, strobes held across the burst and dropped after it.
  always @(negedge clk) begin
    if (!rst) begin
      rb_beat = 0; rb_wcnt = 0; rb_active = 1'b0; rb_drop_chk = 1'b0; mem_resp = 1'b0;
    end else begin
      mem_resp = 1'b0;
      if (rb_drop_chk) begin
        rb_drop_chk = 1'b0;
        check("mem_drop_after_beat4", 256'(mem_read | mem_write), 256'(0));
      end else if (mem_read || mem_write) begin
        rb_active = 1'b1;
        if (rb_wcnt == cur_wait) begin
          check("mem_address", 256'(mem_address), 256'(exp_addr));
          check("mem_op_write", 256'(mem_write), 256'(exp_mwrite));
          if (mem_write) check("mem_wdata", 256'(mem_wdata), 256'(exp_wline[rb_beat*64 +: 64]));
          mem_rdata = mem_line_cur[rb_beat*64 +: 64];
          mem_resp  = 1'b1;
          rb_wcnt   = 0;
          rb_beat++;
          if (rb_beat == 4) begin
            rb_beat = 0; rb_active = 1'b0; rb_drop_chk = 1'b1;
          end
        end else begin
          rb_wcnt++;
        end
      end else if (rb_active) begin
        check("mem_strobe_held", 256'(0), 256'(1));
        rb_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_expect(input vec_t v, input int o);
    exp_addr   = (o == 1) ? v.exp_d_addr : v.exp_i_addr;
    exp_mwrite = (o == 1) && v.d_wr;
    exp_wline  = v.wdata;
  endtask

  task automatic drop_req(input int who);
    if (who == 0) i_pmem_read = 1'b0;
    else begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    last_served = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] pend;
    int         lat;
    int         who;
    int         exp_owner;
    int         served;
    @(posedge clk); #1;
    i_pmem_address = v.i_addr;
    d_pmem_address = v.d_addr;
    d_pmem_wdata   = v.wdata;
    i_pmem_read    = v.i_req;
    d_pmem_read    = v.d_rd;
    d_pmem_write   = v.d_wr;
    mem_line_cur   = v.mem_line;
    cur_wait       = v.waits;
    pend      = {v.d_rd | v.d_wr, v.i_req};
    exp_owner = v.exp_first;
    set_expect(v, exp_owner);
    lat = 0;
    served = 0;
    while (pend != 2'b00 && lat < 400) begin
      @(negedge clk);
      lat++;
      if (i_pmem_resp || d_pmem_resp) begin
        who = d_pmem_resp ? 1 : 0;
        check({tag, "_owner"}, 256'(who), 256'(exp_owner));
        check({tag, "_single_resp"}, 256'(i_pmem_resp & d_pmem_resp), 256'(0));
        check({tag, "_resp_pending"}, 256'(pend[who]), 256'(1));
        if (served == 0) check({tag, "_latency"}, 256'(lat), 256'(v.exp_lat));
        if (who == 0) check({tag, "_i_rdata"}, i_pmem_rdata, v.mem_line);
        else if (!v.d_wr) check({tag, "_d_rdata"}, d_pmem_rdata, v.mem_line);
        pend[who] = 1'b0;
        served++;
        last_served = who;
        exp_owner = (who == 0) ? 1 : 0;
        set_expect(v, exp_owner);
        @(posedge clk); #1;
        drop_req(who);
      end
    end
    if (pend != 2'b00) check({tag, "_timeout"}, 256'(pend), 256'(0));
    repeat (2) begin
      @(negedge clk);
      check({tag, "_quiet"}, 256'(i_pmem_resp | d_pmem_resp), 256'(0));
    end
  endtask

  function automatic vec_t mk(input logic i, input logic dr, input logic dw,
                              input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] eia, input logic [31:0] eda,
                              input logic [255:0] w, input logic [255:0] l,
                              input int waits, input int first, input int lat);
    vec_t v;
    v.i_req = i; v.d_rd = dr; v.d_wr = dw;
    v.i_addr = ia; v.d_addr = da; v.exp_i_addr = eia; v.exp_d_addr = eda;
    v.wdata = w; v.mem_line = l; v.waits = waits; v.exp_first = first; v.exp_lat = lat;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L2 = {64'hA5A5_0003_0000_FFFF, 64'h0123_4567_89AB_CDEF,
                                 64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_1E1E_2D2D_3C3C};
  localparam logic [255:0] W1 = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                                 64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};

  vec_t tbl[7];
  vec_t rv;
  int   t;
  int   got;

  initial begin
    tbl[0] = mk(1, 1, 0, 32'h0000_2004, 32'h0000_3008, 32'h0000_2000, 32'h0000_3000, '0, L2, 0, 1, 6);
    tbl[1] = mk(1, 0, 1, 32'h0000_2040, 32'h0000_3060, 32'h0000_2040, 32'h0000_3060, W1, L1, 0, 1, 6);
    tbl[2] = mk(1, 0, 0, 32'h0000_1234, 32'h0, 32'h0000_1220, 32'h0, '0, L1, 0, 0, 6);
    tbl[3] = mk(0, 0, 1, 32'h0, 32'h8000_0040, 32'h0, 32'h8000_0040, W1, L2, 0, 1, 6);
    tbl[4] = mk(1, 0, 0, 32'h0000_7FFF, 32'h0, 32'h0000_7FE0, 32'h0, '0, L2, 3, 0, 18);
    tbl[5] = mk(0, 1, 1, 32'h0, 32'h0000_ABDF, 32'h0, 32'h0000_ABC0, L2, L1, 0, 1, 6);
    tbl[6] = mk(0, 1, 0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFE0, '0, L2, 1, 1, 10);

    // Reset values
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 256'(dbg_state), 256'(IDLE));
    check("rst_mem_rw", 256'({mem_read, mem_write}), 256'(0));
    check("rst_mem_address", 256'(mem_address), 256'(0));
    check("rst_mem_wdata", 256'(mem_wdata), 256'(0));
    check("rst_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    check("rst_i_rdata", i_pmem_rdata, 256'(0));
    check("rst_d_rdata", d_pmem_rdata, 256'(0));
    do_reset();

    // Directed table (rows 0 and 1 rely on post-reset round-robin state)
    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Client drops its request mid-burst: burst still completes with one resp
    @(posedge clk); #1;
    i_pmem_address = 32'h0000_0517;
    exp_addr = 32'h0000_0500; exp_mwrite = 1'b0; cur_wait = 1; mem_line_cur = L1;
    i_pmem_read = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_pmem_read = 1'b0;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (i_pmem_resp) begin
        got++;
        check("drop_rdata", i_pmem_rdata, L1);
      end
      check("drop_no_dresp", 256'(d_pmem_resp), 256'(0));
    end
    check("drop_resp_count", 256'(got), 256'(1));
    last_served = 0;

    // Reset during beat 2 of an icache read aborts it with no resp
    @(posedge clk); #1;
    i_pmem_address = 32'h0000_0640;
    exp_addr = 32'h0000_0640; exp_mwrite = 1'b0; cur_wait = 2; mem_line_cur = L2;
    i_pmem_read = 1'b1;
    t = 0;
    while (rb_beat != 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("abort_reached_beat2", 256'(t < 100), 256'(1));
    #3 rst = 1'b0;
    i_pmem_read = 1'b0;
    #1;
    check("abort_state", 256'(dbg_state), 256'(IDLE));
    check("abort_mem_rw", 256'({mem_read, mem_write}), 256'(0));
    check("abort_mem_address", 256'(mem_address), 256'(0));
    check("abort_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    check("abort_i_rdata", i_pmem_rdata, 256'(0));
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    end
    @(posedge clk); #1 rst = 1'b1;
    last_served = 0;
    run_vec(tbl[2], "after_abort");

    // Randomized transactions against the arbitration model
    for (int n = 0; n < 30; n++) begin
      rv.i_req = 1'($urandom_range(0, 1));
      rv.d_rd  = 1'($urandom_range(0, 1));
      rv.d_wr  = 1'($urandom_range(0, 1));
      if (!rv.i_req && !rv.d_rd && !rv.d_wr) rv.i_req = 1'b1;
      rv.i_addr = $urandom;
      rv.d_addr = $urandom;
      rv.exp_i_addr = line_addr(rv.i_addr);
      rv.exp_d_addr = line_addr(rv.d_addr);
      rv.wdata    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rv.mem_line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rv.waits     = $urandom_range(0, 3);
      rv.exp_first = pick_first(rv.i_req, rv.d_rd | rv.d_wr);
      rv.exp_lat   = 6 + 4 * rv.waits;
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so a stuck DUT cannot hang the run
  initial begin
    #1000000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
